// File: rtl/race_engine_multi_if.sv
// Bundle of game-control inputs and renderer-facing outputs for race_engine_multi.
// The master modport drives the controls; the slave modport is the game core.
interface race_engine_multi_if #(
    parameter int PLAYERS = 4,
    parameter int POS_W   = 6,
    parameter int WIN_W   = 2
);
    logic                       ena;
    logic [PLAYERS-1:0]         btn_i;
    logic                       start_i;
    logic [PLAYERS*POS_W-1:0]   pos_o;
    logic [1:0]                 state_o;
    logic [PLAYERS-1:0]         press_o;
    logic                       winner_valid_o;
    logic [WIN_W-1:0]           winner_o;

    modport master (
        output ena, btn_i, start_i,
        input  pos_o, state_o, press_o, winner_valid_o, winner_o
    );

    modport slave (
        input  ena, btn_i, start_i,
        output pos_o, state_o, press_o, winner_valid_o, winner_o
    );
endinterface

// File: rtl/race_engine_multi.sv
// Multi-lane LED racer core: button sync/debounce plus IDLE/COUNTDOWN/RACE/FINISH game FSM.
// Optional macro RACER_FALSE_START_EN: a press during COUNTDOWN restarts the countdown.
module race_engine_multi #(
    parameter int PLAYERS          = 4,
    parameter int TRACK_LEN        = 48,
    parameter int POS_W            = 6,
    parameter int WIN_W            = 2,
    parameter int DEBOUNCE_CYCLES  = 1000,
    parameter int COUNTDOWN_CYCLES = 12000000
) (
    input  logic                clk,
    input  logic                rst_n,
    race_engine_multi_if.slave  bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CD_W = (COUNTDOWN_CYCLES > 1) ? $clog2(COUNTDOWN_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(COUNTDOWN_CYCLES - 1);
    localparam logic [POS_W-1:0] LAST    = POS_W'(TRACK_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_RACE      = 2'd2,
        S_FINISH    = 2'd3
    } state_t;

    logic [PLAYERS-1:0] r_sync1;
    logic [PLAYERS-1:0] r_sync2;
    logic [PLAYERS-1:0] r_db;
    logic [PLAYERS-1:0] r_db_q;
    logic [PLAYERS-1:0] r_press;
    logic [DB_W-1:0]    r_db_cnt [PLAYERS];

    state_t             r_state;
    state_t             w_state_nx;
    logic [CD_W-1:0]    r_cd;
    logic [CD_W-1:0]    w_cd_nx;
    logic [POS_W-1:0]   r_pos    [PLAYERS];
    logic [POS_W-1:0]   w_pos_nx [PLAYERS];
    logic [WIN_W-1:0]   r_win;
    logic [WIN_W-1:0]   w_win_nx;
    logic               r_wv;
    logic               w_wv_nx;
    logic               w_found;
    logic [PLAYERS*POS_W-1:0] w_pos_flat;

    // Input path: independent of ena and game state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_q  <= '0;
            r_press <= '0;
            for (int unsigned i = 0; i < PLAYERS; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= bus.btn_i;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            r_press <= r_db & ~r_db_q;
            for (int unsigned i = 0; i < PLAYERS; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_db[i]     <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cd    <= '0;
            r_win   <= '0;
            r_wv    <= 1'b0;
            for (int unsigned i = 0; i < PLAYERS; i++) begin
                r_pos[i] <= '0;
            end
        end else begin
            r_state <= w_state_nx;
            r_cd    <= w_cd_nx;
            r_win   <= w_win_nx;
            r_wv    <= w_wv_nx;
            r_pos   <= w_pos_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cd_nx    = r_cd;
        w_pos_nx   = r_pos;
        w_win_nx   = r_win;
        w_wv_nx    = r_wv;
        w_found    = 1'b0;
        if (bus.ena) begin
            unique case (r_state)
                S_IDLE: begin
                    for (int unsigned i = 0; i < PLAYERS; i++) begin
                        w_pos_nx[i] = '0;
                    end
                    if (bus.start_i) begin
                        w_state_nx = S_COUNTDOWN;
                        w_cd_nx    = CD_LOAD;
                    end
                end
                S_COUNTDOWN: begin
`ifdef RACER_FALSE_START_EN
                    if (|r_press) begin
                        w_cd_nx = CD_LOAD;
                    end else if (r_cd == '0) begin
                        w_state_nx = S_RACE;
                    end else begin
                        w_cd_nx = r_cd - CD_W'(1);
                    end
`else
                    if (r_cd == '0) begin
                        w_state_nx = S_RACE;
                    end else begin
                        w_cd_nx = r_cd - CD_W'(1);
                    end
`endif
                end
                S_RACE: begin
                    // Ascending scan with a found flag makes the lowest finishing lane win a tie.
                    for (int unsigned i = 0; i < PLAYERS; i++) begin
                        if (r_press[i] && (r_pos[i] != LAST)) begin
                            w_pos_nx[i] = r_pos[i] + POS_W'(1);
                        end
                        if ((w_pos_nx[i] == LAST) && !w_found) begin
                            w_found  = 1'b1;
                            w_win_nx = WIN_W'(i);
                        end
                    end
                    if (w_found) begin
                        w_state_nx = S_FINISH;
                        w_wv_nx    = 1'b1;
                    end
                end
                S_FINISH: begin
                    if (bus.start_i) begin
                        w_state_nx = S_IDLE;
                        w_win_nx   = '0;
                        w_wv_nx    = 1'b0;
                        for (int unsigned i = 0; i < PLAYERS; i++) begin
                            w_pos_nx[i] = '0;
                        end
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_pos_flat = '0;
        for (int unsigned i = 0; i < PLAYERS; i++) begin
            w_pos_flat[i*POS_W +: POS_W] = r_pos[i];
        end
    end

    assign bus.pos_o          = w_pos_flat;
    assign bus.state_o        = r_state;
    assign bus.press_o        = r_press;
    assign bus.winner_valid_o = r_wv;
    assign bus.winner_o       = r_win;

endmodule
